// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind uart_rx: SOF, LEN, payload, XOR checksum, with an inter-byte timeout.
// Define FRAME_ACK_EN to add the ACK/NAK handshake towards uart_tx.
module uart_rx_frame_parser #(
    parameter int unsigned MAX_LEN        = 8,
    parameter logic [7:0]  SOF            = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [8*MAX_LEN-1:0]   frame_data,
    output logic [3:0]             frame_len,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic [7:0]             last_byte,
    output logic                   busy
`ifdef FRAME_ACK_EN
    ,
    output logic [7:0]             ack_byte,
    output logic                   ack_start,
    input  logic                   ack_done
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             len_q, len_d;
    logic [3:0]             idx_q, idx_d;
    logic [7:0]             chk_q, chk_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             buf_q [MAX_LEN];
    logic [7:0]             buf_d [MAX_LEN];
    logic [8*MAX_LEN-1:0]   frame_data_q, frame_data_d;
    logic [3:0]             frame_len_q, frame_len_d;
    logic [7:0]             last_byte_q, last_byte_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   timeout_hit;
    logic                   len_bad;
    logic                   chk_ok;
    logic                   last_pay;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_q != S_IDLE) && !rx_valid &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign len_bad     = rx_byte > 8'(MAX_LEN);
    assign chk_ok      = rx_byte == chk_q;
    assign last_pay    = idx_q == (len_q - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SOF) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (len_bad) begin
                        state_d = S_IDLE;
                    end else if (rx_byte == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (last_pay) begin
                        state_d = S_CHK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CHK: begin
                if (rx_valid || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d         = len_q;
        idx_d         = idx_q;
        chk_d         = chk_q;
        buf_d         = buf_q;
        frame_data_d  = frame_data_q;
        frame_len_d   = frame_len_q;
        last_byte_d   = last_byte_q;
        err_code_d    = err_code_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        if (state_q == S_IDLE || rx_valid || timeout_hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SOF) begin
                    chk_d = '0;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    len_d = rx_byte[3:0];
                    chk_d = rx_byte;
                    idx_d = '0;
                    if (len_bad) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) begin
                            buf_d[i] = rx_byte;
                        end
                    end
                    chk_d = chk_q ^ rx_byte;
                    idx_d = idx_q + 4'd1;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (chk_ok) begin
                        // Shadow buffer may hold stale bytes past len; mask them off.
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            frame_data_d[8*i +: 8] = (4'(i) < len_q) ? buf_q[i] : '0;
                            if (len_q != 4'd0 && 4'(i) == len_q - 4'd1) begin
                                last_byte_d = buf_q[i];
                            end
                        end
                        frame_len_d   = len_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                    end
                end
            end
            default: ;
        endcase

        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            cnt_q         <= '0;
            frame_data_q  <= '0;
            frame_len_q   <= '0;
            last_byte_q   <= '0;
            err_code_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            len_q         <= len_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            cnt_q         <= cnt_d;
            frame_data_q  <= frame_data_d;
            frame_len_q   <= frame_len_d;
            last_byte_q   <= last_byte_d;
            err_code_q    <= err_code_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            buf_q         <= buf_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_len   = frame_len_q;
    assign last_byte   = last_byte_q;
    assign err_code    = err_code_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = state_q != S_IDLE;

`ifdef FRAME_ACK_EN
    logic [7:0] ack_byte_q, ack_byte_d;
    logic       ack_start_q, ack_start_d;

    // Single pending slot: a new result overrides both the old byte and a same-cycle ack_done.
    always_comb begin
        ack_byte_d  = ack_byte_q;
        ack_start_d = ack_start_q;
        if (ack_done) begin
            ack_start_d = 1'b0;
        end
        if (frame_valid_q) begin
            ack_byte_d  = 8'h06;
            ack_start_d = 1'b1;
        end else if (frame_err_q) begin
            ack_byte_d  = 8'h15;
            ack_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_byte_q  <= '0;
            ack_start_q <= 1'b0;
        end else begin
            ack_byte_q  <= ack_byte_d;
            ack_start_q <= ack_start_d;
        end
    end

    assign ack_byte  = ack_byte_q;
    assign ack_start = ack_start_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench for uart_rx_frame_parser: directed frames plus randomized traffic
// compared each cycle against a queue-based frame model.
module tb_uart_rx_frame_parser;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TIMEOUT = 100;
    localparam logic [7:0]  SOF_B   = 8'h01;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic [8*MAX_LEN-1:0] frame_data;
    logic [3:0]           frame_len;
    logic                 frame_valid;
    logic                 frame_err;
    logic [1:0]           err_code;
    logic [7:0]           last_byte;
    logic                 busy;
`ifdef FRAME_ACK_EN
    logic [7:0]           ack_byte;
    logic                 ack_start;
    logic                 ack_done = 1'b0;
`endif

    uart_rx_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .SOF            (SOF_B),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_data  (frame_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .last_byte   (last_byte),
        .busy        (busy)
`ifdef FRAME_ACK_EN
        ,
        .ack_byte    (ack_byte),
        .ack_start   (ack_start),
        .ack_done    (ack_done)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect bytes after SOF, judge the frame once LEN+2 bytes are in.
    logic [7:0]           m_q[$];
    bit                   m_in = 1'b0;
    int                   m_gap = 0;
    logic [8*MAX_LEN-1:0] e_data = '0;
    logic [3:0]           e_len = '0;
    logic [7:0]           e_last = '0;
    logic [1:0]           e_code = '0;
    logic                 e_fv = 1'b0;
    logic                 e_fe = 1'b0;
    logic                 e_busy = 1'b0;

    always @(posedge clk) begin
        int L;
        logic [7:0] x;
        e_fv = 1'b0;
        e_fe = 1'b0;
        if (rst) begin
            m_in = 1'b0; m_q.delete(); m_gap = 0;
            e_data = '0; e_len = '0; e_last = '0; e_code = '0;
        end else if (m_in) begin
            if (rx_valid) begin
                m_q.push_back(rx_byte);
                m_gap = 0;
                L = int'(m_q[0]);
                if (m_q.size() == 1 && L > int'(MAX_LEN)) begin
                    e_fe = 1'b1; e_code = 2'd2; m_in = 1'b0;
                end else if (m_q.size() == L + 2) begin
                    x = '0;
                    for (int k = 0; k <= L; k++) x = x ^ m_q[k];
                    if (m_q[L+1] == x) begin
                        e_data = '0;
                        for (int k = 0; k < L; k++) e_data[8*k +: 8] = m_q[k+1];
                        e_len = 4'(L);
                        if (L > 0) e_last = m_q[L];
                        e_fv = 1'b1;
                    end else begin
                        e_fe = 1'b1; e_code = 2'd1;
                    end
                    m_in = 1'b0;
                end
            end else begin
                m_gap++;
                if (m_gap == int'(TIMEOUT)) begin
                    e_fe = 1'b1; e_code = 2'd3; m_in = 1'b0;
                end
            end
        end else if (rx_valid && rx_byte == SOF_B) begin
            m_in = 1'b1; m_q.delete(); m_gap = 0;
        end
        e_busy = m_in;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("frame_valid", frame_valid, e_fv);
            check("frame_err",   frame_err,   e_fe);
            check("err_code",    err_code,    e_code);
            check("frame_data",  frame_data,  e_data);
            check("frame_len",   frame_len,   e_len);
            check("last_byte",   last_byte,   e_last);
            check("busy",        busy,        e_busy);
        end
    end

    // Called at a negedge; the byte is sampled at the following posedge; returns at the next negedge.
    task automatic drive(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input int n, input logic [63:0] seq);
        for (int k = 0; k < n; k++) drive(1'b1, seq[8*(n-1-k) +: 8]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k_hit;
        int L;
        int gap;
        logic [7:0] x;
        logic [7:0] b;

        rst = 1'b1; rx_valid = 1'b0; rx_byte = '0;
        @(negedge clk);
        drive(1'b0, 8'h00);
        chk_en = 1'b1;
        check("rst_frame_data", frame_data, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00);

        send(5, 64'h01_02_41_42_01);
        check("good_fv", frame_valid, 1'b1);
        check("good_len", frame_len, 4'd2);
        check("good_data", frame_data[15:0], 16'h4241);
        check("good_last", last_byte, 8'h42);
        drive(1'b0, 8'h00);

        send(5, 64'h01_02_41_42_00);
        check("badchk_fe", frame_err, 1'b1);
        check("badchk_code", err_code, 2'd1);
        check("badchk_data", frame_data[15:0], 16'h4241);
        check("badchk_last", last_byte, 8'h42);

        send(2, 64'h01_09);
        check("badlen_fe", frame_err, 1'b1);
        check("badlen_code", err_code, 2'd2);
        check("badlen_busy", busy, 1'b0);
        send(3, 64'h01_00_00);
        check("len0_fv", frame_valid, 1'b1);
        check("len0_len", frame_len, 4'd0);
        check("len0_last", last_byte, 8'h42);

        send(6, 64'h7F_33_01_01_05_04);
        check("garbage_fv", frame_valid, 1'b1);
        check("garbage_last", last_byte, 8'h05);

        send(3, 64'h01_02_41);
        k_hit = -1;
        for (int k = 1; k <= 150; k++) begin
            drive(1'b0, 8'h00);
            if (frame_err) begin
                k_hit = k;
                break;
            end
        end
        check("timeout_latency", 64'(k_hit), 64'd100);
        check("timeout_code", err_code, 2'd3);

        send(3, 64'h01_02_41);
        repeat (TIMEOUT - 1) drive(1'b0, 8'h00);
        drive(1'b1, 8'h42);
        check("expiry_byte_wins_fe", frame_err, 1'b0);
        check("expiry_byte_wins_busy", busy, 1'b1);
        drive(1'b1, 8'h01);
        check("expiry_then_good", frame_valid, 1'b1);

        send(3, 64'h01_03_11);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        check("midrst_data", frame_data, 64'h0);
        check("midrst_last", last_byte, 8'h00);
        check("midrst_fe", frame_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        drive(1'b0, 8'h00);

`ifdef FRAME_ACK_EN
        send(5, 64'h01_02_41_42_01);
        drive(1'b0, 8'h00);
        send(5, 64'h01_02_41_42_00);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        check("ack_pending_byte", ack_byte, 8'h15);
        check("ack_pending_start", ack_start, 1'b1);
        ack_done = 1'b1;
        drive(1'b0, 8'h00);
        ack_done = 1'b0;
        check("ack_done_drops", ack_start, 1'b0);
`endif

        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                drive(1'b0, 8'h00);
                rst = 1'b0;
            end
            repeat ($urandom_range(0, 2)) drive(1'b1, 8'($urandom_range(0, 255)));
            L = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 20)) : int'($urandom_range(0, MAX_LEN));
            x = 8'(L);
            drive(1'b1, SOF_B);
            drive(1'b1, 8'(L));
            for (int k = 0; k <= L; k++) begin
                if ($urandom_range(0, 99) < 3) gap = int'($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
                else gap = int'($urandom_range(0, 3));
                repeat (gap) drive(1'b0, 8'h00);
                if (k < L) begin
                    b = 8'($urandom_range(0, 255));
                    x = x ^ b;
                end else begin
                    b = ($urandom_range(0, 99) < 70) ? x : 8'(x ^ 8'($urandom_range(1, 255)));
                end
                drive(1'b1, b);
            end
            repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00);
        end

        repeat (TIMEOUT + 5) drive(1'b0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
